chip8_mem_arbiter: RTL and testbench
====================================

// Module: chip8_mem_arbiter
// PURPOSE
//  Shares the single-port 4 KiB CHIP-8 RAM among three requesters: ROM loader (boot-time byte stream),
//  CPU core (fetch/BCD/Fx55/Fx65/sprite traffic) and debug reader. Registers one access per cycle into the RAM,
//  returns read data with fixed latency, auto-addresses loader writes from LOAD_BASE and halts the CPU while loading.
// PARAMETERS
//  ADDR_W     12       RAM address width (4096 bytes)
//  DATA_W     8        RAM data width
//  LOAD_BASE  12'h200  first address written by loader after load_start
// PORTS
//  clk          in   1       clock
//  reset        in   1       asynchronous, active-high reset
//  load_mode    in   1       1 = boot load in progress; only loader serviced
//  load_start   in   1       pulse: reset loader address counter to LOAD_BASE
//  ld_req       in   1       loader has byte ld_wdata to write
//  ld_wdata     in   DATA_W  loader write byte
//  ld_gnt       out  1       pulse: loader byte issued to RAM
//  ld_count     out  ADDR_W  bytes accepted since load_start
//  ld_err       out  1       sticky: write attempted past top of RAM
//  cpu_req      in   1       CPU access request
//  cpu_we       in   1       1 = write, 0 = read
//  cpu_addr     in   ADDR_W  CPU address
//  cpu_wdata    in   DATA_W  CPU write byte
//  cpu_gnt      out  1       pulse: CPU access issued
//  cpu_rvalid   out  1       pulse: cpu_rdata valid
//  cpu_halt     out  1       CPU must not advance state
//  dbg_req      in   1       debug read request
//  dbg_addr     in   ADDR_W  debug read address
//  dbg_gnt      out  1       pulse: debug read issued
//  dbg_rvalid   out  1       pulse: dbg_rdata valid
//  rdata        out  DATA_W  shared read data (= mem_rdata), qualify with *_rvalid
//  mem_en/mem_we out 1 each  RAM enable / write enable (registered)
//  mem_addr     out  ADDR_W  RAM address (registered)
//  mem_wdata    out  DATA_W  RAM write data (registered)
//  mem_rdata    in   DATA_W  RAM read data, valid 1 cycle after mem_en&!mem_we
// BEHAVIOUR
//  - Reset: all gnt/rvalid/mem_en/mem_we 0, mem_addr/mem_wdata 0, ld_count 0, ld_err 0, load ptr = LOAD_BASE,
//    rr pointer = CPU, cpu_halt 1 (released first cycle after reset deasserts with load_mode 0). Reset mid-access drops it.
//  - Timing: requests sampled at edge E; winner's mem_* and *_gnt driven in cycle after E; for reads *_rvalid pulses
//    the following cycle with rdata = mem_rdata. Read latency req-sample -> rvalid = 2 cycles.
//  - Requester holds req and fields stable until its gnt; requester granted in cycle C is masked from arbitration at
//    end of C (no double issue). Other requester may be granted back-to-back.
//  - FSM RUN: round-robin CPU/debug; winner becomes lowest priority next time. Loader ignored (ld_req dropped, no gnt).
//  - FSM LOAD (entered when load_mode=1 sampled): only loader eligible; cpu_req/dbg_req ignored. Loader write goes to
//    ptr; ptr++, ld_count++ on each ld_gnt. If ptr already wrapped past 12'hFFF: no mem access, no gnt, ld_err set.
//  - cpu_halt = 1 in LOAD and in DRAIN; DRAIN (load_mode fell) waits until no read is in flight, then -> RUN, halt 0.
//  - load_start: ptr = LOAD_BASE, ld_count = 0, ld_err = 0; same-cycle ld_req ignored (counter restart wins).
//  - load_mode rising while CPU/debug read in flight: rvalid for it still delivered; no new CPU/debug grant.
//  - At most one mem access per cycle; mem_en=0 when no grant. Writes: mem_we=1, no rvalid.
// TESTING
//  - Reset, load_mode=1, load_start, stream bytes 0x12,0x34,0x56 -> RAM[0x200..0x202]=12,34,56, ld_count=3, cpu_halt=1.
//  - load_mode=0 -> cpu_halt falls after drain; cpu read 0x200 -> cpu_rvalid 2 cycles after req sampled, rdata 0x12.
//  - cpu_req and dbg_req held continuously -> grants alternate CPU,DBG,CPU,DBG; each requester never granted twice in a row.
//  - load 3584 bytes from 0x200 then one more -> last goes to 0xFFF, next byte: no ld_gnt, ld_err=1, RAM unchanged.
//  - CPU write 0xAB@0x300 then debug read 0x300 -> dbg_rvalid with rdata 0xAB; no cpu_rvalid for the write.
//  - Assert reset during CPU read grant -> next cycle all gnt/rvalid/mem_en 0, ld_count 0, cpu_halt 1.

Source files
------------

// File: rtl/chip8_mem_arbiter_if.sv
// chip8_mem_arbiter_if
//   Bundles the loader, CPU and debug requester handshakes plus the RAM port
//   of the CHIP-8 memory arbiter.
//   slave  : arbiter view (requests and mem_rdata in; grants, valids, RAM controls out)
//   master : requester/RAM view (the mirror image)
//   Parameters: ADDR_W (RAM address width), DATA_W (RAM data width)
interface chip8_mem_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
);
  // loader
  logic              load_mode;
  logic              load_start;
  logic              ld_req;
  logic [DATA_W-1:0] ld_wdata;
  logic              ld_gnt;
  logic [ADDR_W-1:0] ld_count;
  logic              ld_err;
  // CPU
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic              cpu_halt;
  // debug reader
  logic              dbg_req;
  logic [ADDR_W-1:0] dbg_addr;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  // shared read data and RAM port
  logic [DATA_W-1:0] rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  load_mode, load_start, ld_req, ld_wdata,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dbg_req, dbg_addr, mem_rdata,
    output ld_gnt, ld_count, ld_err,
    output cpu_gnt, cpu_rvalid, cpu_halt,
    output dbg_gnt, dbg_rvalid, rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output load_mode, load_start, ld_req, ld_wdata,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dbg_req, dbg_addr, mem_rdata,
    input  ld_gnt, ld_count, ld_err,
    input  cpu_gnt, cpu_rvalid, cpu_halt,
    input  dbg_gnt, dbg_rvalid, rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/chip8_mem_arbiter.sv
// chip8_mem_arbiter
//   Shares the single-port 4 KiB CHIP-8 RAM between the boot ROM loader, the
//   CPU core and a debug reader. One access per cycle is registered onto the
//   RAM port; read data returns on rdata with the matching *_rvalid pulse.
//   While load_mode is high only the loader is served (auto-addressed from
//   LOAD_BASE) and the CPU is halted until outstanding reads have drained.
// Ports
//   clk    : clock
//   reset  : asynchronous, active-high reset
//   bus    : chip8_mem_arbiter_if.slave (requester handshakes + RAM port)
module chip8_mem_arbiter #(
  parameter int                ADDR_W    = 12,
  parameter int                DATA_W    = 8,
  parameter logic [ADDR_W-1:0] LOAD_BASE = 12'h200
) (
  input logic                clk,
  input logic                reset,
  chip8_mem_arbiter_if.slave bus
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [ADDR_W-1:0] ONE_CNT = 1;
  localparam logic [ADDR_W:0]   ONE_PTR = 1;

  logic [1:0]        r_state;
  logic [1:0]        w_stateNext;
  logic              r_rrCpu;
  logic [ADDR_W:0]   r_ldPtr;
  logic [ADDR_W-1:0] r_ldCount;
  logic              r_ldErr;
  logic              r_ldGnt;
  logic              r_cpuGnt;
  logic              r_dbgGnt;
  logic              r_cpuRvalid;
  logic              r_dbgRvalid;
  logic              r_memEn;
  logic              r_memWe;
  logic [ADDR_W-1:0] r_memAddr;
  logic [DATA_W-1:0] r_memWdata;

  logic w_readInFlight;
  logic w_ldElig;
  logic w_ldOverflow;
  logic w_ldWin;
  logic w_cpuElig;
  logic w_dbgElig;
  logic w_cpuWin;
  logic w_dbgWin;

  // Only CPU/debug issue reads, so a read on the RAM port is one whose data
  // has not yet come back.
  assign w_readInFlight = r_memEn & ~r_memWe;

  // A requester granted this cycle still shows its req; mask it so the same
  // request is not issued twice. load_start wins over a coincident ld_req.
  assign w_ldElig     = bus.load_mode & bus.ld_req & ~bus.load_start & ~r_ldGnt;
  assign w_ldOverflow = r_ldPtr[ADDR_W];
  assign w_ldWin      = w_ldElig & ~w_ldOverflow;

  assign w_cpuElig = ~bus.load_mode & (r_state == ST_RUN) & bus.cpu_req & ~r_cpuGnt;
  assign w_dbgElig = ~bus.load_mode & (r_state == ST_RUN) & bus.dbg_req & ~r_dbgGnt;
  assign w_cpuWin  = w_cpuElig & (~w_dbgElig | r_rrCpu);
  assign w_dbgWin  = w_dbgElig & (~w_cpuElig | ~r_rrCpu);

  // DRAIN is also the reset state so the CPU stays halted until the first
  // edge after reset decides between RUN and LOAD.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_RUN:   if (bus.load_mode) w_stateNext = ST_LOAD;
      ST_LOAD:  if (!bus.load_mode) w_stateNext = ST_DRAIN;
      ST_DRAIN: begin
        if (bus.load_mode)      w_stateNext = ST_LOAD;
        else if (!w_readInFlight) w_stateNext = ST_RUN;
      end
      default:  w_stateNext = ST_DRAIN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_DRAIN;
    else       r_state <= w_stateNext;
  end

  // Loader pointer carries one extra bit so running off the top of RAM is
  // visible instead of silently wrapping to address 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ldPtr   <= {1'b0, LOAD_BASE};
      r_ldCount <= '0;
      r_ldErr   <= 1'b0;
    end else if (bus.load_start) begin
      r_ldPtr   <= {1'b0, LOAD_BASE};
      r_ldCount <= '0;
      r_ldErr   <= 1'b0;
    end else if (w_ldWin) begin
      r_ldPtr   <= r_ldPtr + ONE_PTR;
      r_ldCount <= r_ldCount + ONE_CNT;
    end else if (w_ldElig && w_ldOverflow) begin
      r_ldErr   <= 1'b1;
    end
  end

  // Registered RAM port and grants. Read valids follow the grant by one
  // cycle, matching the RAM's one-cycle read latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ldGnt     <= 1'b0;
      r_cpuGnt    <= 1'b0;
      r_dbgGnt    <= 1'b0;
      r_cpuRvalid <= 1'b0;
      r_dbgRvalid <= 1'b0;
      r_memEn     <= 1'b0;
      r_memWe     <= 1'b0;
      r_memAddr   <= '0;
      r_memWdata  <= '0;
      r_rrCpu     <= 1'b1;
    end else begin
      r_ldGnt     <= w_ldWin;
      r_cpuGnt    <= w_cpuWin;
      r_dbgGnt    <= w_dbgWin;
      r_cpuRvalid <= r_cpuGnt & ~r_memWe;
      r_dbgRvalid <= r_dbgGnt;
      r_memEn     <= w_ldWin | w_cpuWin | w_dbgWin;
      r_memWe     <= w_ldWin | (w_cpuWin & bus.cpu_we);
      if (w_ldWin) begin
        r_memAddr  <= r_ldPtr[ADDR_W-1:0];
        r_memWdata <= bus.ld_wdata;
      end else if (w_cpuWin) begin
        r_memAddr  <= bus.cpu_addr;
        r_memWdata <= bus.cpu_wdata;
      end else if (w_dbgWin) begin
        r_memAddr  <= bus.dbg_addr;
      end
      // the winner drops to lowest priority for the next contest
      if (w_cpuWin || w_dbgWin) r_rrCpu <= w_dbgWin;
    end
  end

  assign bus.ld_gnt     = r_ldGnt;
  assign bus.ld_count   = r_ldCount;
  assign bus.ld_err     = r_ldErr;
  assign bus.cpu_gnt    = r_cpuGnt;
  assign bus.cpu_rvalid = r_cpuRvalid;
  assign bus.cpu_halt   = (r_state != ST_RUN);
  assign bus.dbg_gnt    = r_dbgGnt;
  assign bus.dbg_rvalid = r_dbgRvalid;
  assign bus.rdata      = bus.mem_rdata;
  assign bus.mem_en     = r_memEn;
  assign bus.mem_we     = r_memWe;
  assign bus.mem_addr   = r_memAddr;
  assign bus.mem_wdata  = r_memWdata;

endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// tb_chip8_mem_arbiter
//   Self-checking bench for chip8_mem_arbiter: boot load, drain, CPU/debug
//   round-robin, a table of single accesses, a randomized CPU/debug traffic
//   run against a RAM shadow model, loader overflow and reset mid-access.
module tb_chip8_mem_arbiter;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 8;

  logic clk = 1'b0;
  logic reset;
  logic ramClear;
  int   compared   = 0;
  int   mismatched = 0;

  logic [7:0] ram [0:4095];
  logic [7:0] memRdata;
  logic [7:0] shadow [0:4095];

  typedef struct {
    logic       isDbg;
    logic       we;
    logic [11:0] addr;
    logic [7:0] wdata;
    logic [7:0] expRdata;
  } vec_t;

  vec_t vecs [0:6];

  chip8_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  chip8_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOAD_BASE(12'h200)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Single-port RAM with one-cycle read latency
  assign bus.mem_rdata = memRdata;
  always @(posedge clk) begin
    if (ramClear) begin
      for (int i = 0; i < 4096; i++) ram[i] <= 8'h00;
      memRdata <= 8'h00;
    end else if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            memRdata <= ram[bus.mem_addr];
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: time limit reached, got running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic failNote(input string name);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: got timeout, expected response", name);
  endtask

  // One CPU or debug access from the table, issued from an idle arbiter
  task automatic applyStimulus(input vec_t v, input int idx);
    bit got = 0;
    int lat = 0;
    string tag = $sformatf("vec%0d", idx);
    if (v.isDbg) begin
      bus.dbg_req = 1'b1; bus.dbg_addr = v.addr;
    end else begin
      bus.cpu_req = 1'b1; bus.cpu_we = v.we; bus.cpu_addr = v.addr; bus.cpu_wdata = v.wdata;
    end
    for (int c = 1; c <= 8 && !got; c++) begin
      @(negedge clk);
      if (v.isDbg ? bus.dbg_gnt : bus.cpu_gnt) begin got = 1; lat = c; end
    end
    bus.cpu_req = 1'b0;
    bus.dbg_req = 1'b0;
    if (!got) failNote({tag, " gnt"});
    else begin
      checkOutput({tag, " gnt latency"}, 32'(lat), 1);
      checkOutput({tag, " other gnt"}, 32'(v.isDbg ? bus.cpu_gnt : bus.dbg_gnt), 0);
      checkOutput({tag, " mem_en"}, 32'(bus.mem_en), 1);
      checkOutput({tag, " mem_we"}, 32'(bus.mem_we), 32'(v.we));
      checkOutput({tag, " mem_addr"}, 32'(bus.mem_addr), 32'(v.addr));
      if (v.we) checkOutput({tag, " mem_wdata"}, 32'(bus.mem_wdata), 32'(v.wdata));
      @(negedge clk);
      checkOutput({tag, " own rvalid"}, 32'(v.isDbg ? bus.dbg_rvalid : bus.cpu_rvalid), 32'(!v.we));
      checkOutput({tag, " other rvalid"}, 32'(v.isDbg ? bus.cpu_rvalid : bus.dbg_rvalid), 0);
      if (!v.we) checkOutput({tag, " rdata"}, 32'(bus.rdata), 32'(v.expRdata));
    end
  endtask

  // One loader byte; returns at the negedge where ld_gnt was seen
  task automatic loadByte(input logic [7:0] data, input logic [11:0] expAddr, input string tag);
    bit got = 0;
    bus.ld_req = 1'b1;
    bus.ld_wdata = data;
    for (int c = 0; c < 4 && !got; c++) begin
      @(negedge clk);
      if (bus.ld_gnt) got = 1;
    end
    bus.ld_req = 1'b0;
    if (!got) failNote({tag, " ld_gnt"});
    else begin
      checkOutput({tag, " mem_we"}, 32'(bus.mem_we), 1);
      checkOutput({tag, " mem_addr"}, 32'(bus.mem_addr), 32'(expAddr));
      checkOutput({tag, " mem_wdata"}, 32'(bus.mem_wdata), 32'(data));
    end
  endtask

  // Randomized traffic model state
  logic       cReq, cWe, cDrv, cGntPrev, cRdPend;
  logic [11:0] cAddr;
  logic [7:0] cWd, cRdExp;
  logic       dReq, dDrv, dGntPrev, dRdPend;
  logic [11:0] dAddr;
  logic [7:0] dRdExp;
  logic       lastWasDbg;
  int         winner;
  bit         sawGnt, sawEn;
  logic [7:0] lastByte;

  initial begin
    vecs[0] = '{1'b0, 1'b1, 12'h300, 8'hAB, 8'h00};
    vecs[1] = '{1'b1, 1'b0, 12'h300, 8'h00, 8'hAB};
    vecs[2] = '{1'b0, 1'b0, 12'h200, 8'h00, 8'h12};
    vecs[3] = '{1'b0, 1'b1, 12'hFFF, 8'h55, 8'h00};
    vecs[4] = '{1'b1, 1'b0, 12'hFFF, 8'h00, 8'h55};
    vecs[5] = '{1'b0, 1'b0, 12'h300, 8'h00, 8'hAB};
    vecs[6] = '{1'b1, 1'b0, 12'h202, 8'h00, 8'h56};

    bus.load_mode = 1'b1; bus.load_start = 1'b0; bus.ld_req = 1'b0; bus.ld_wdata = 8'h00;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 12'h000; bus.cpu_wdata = 8'h00;
    bus.dbg_req = 1'b0; bus.dbg_addr = 12'h000;
    reset = 1'b1;
    ramClear = 1'b1;
    repeat (3) @(negedge clk);

    // reset state
    checkOutput("reset ld_gnt", 32'(bus.ld_gnt), 0);
    checkOutput("reset cpu_gnt", 32'(bus.cpu_gnt), 0);
    checkOutput("reset dbg_gnt", 32'(bus.dbg_gnt), 0);
    checkOutput("reset cpu_rvalid", 32'(bus.cpu_rvalid), 0);
    checkOutput("reset dbg_rvalid", 32'(bus.dbg_rvalid), 0);
    checkOutput("reset mem_en", 32'(bus.mem_en), 0);
    checkOutput("reset mem_we", 32'(bus.mem_we), 0);
    checkOutput("reset mem_addr", 32'(bus.mem_addr), 0);
    checkOutput("reset mem_wdata", 32'(bus.mem_wdata), 0);
    checkOutput("reset ld_count", 32'(bus.ld_count), 0);
    checkOutput("reset ld_err", 32'(bus.ld_err), 0);
    checkOutput("reset cpu_halt", 32'(bus.cpu_halt), 1);
    ramClear = 1'b0;
    reset = 1'b0;
    @(negedge clk);

    // boot load of three bytes
    bus.load_start = 1'b1;
    @(negedge clk);
    bus.load_start = 1'b0;
    loadByte(8'h12, 12'h200, "boot0");
    loadByte(8'h34, 12'h201, "boot1");
    loadByte(8'h56, 12'h202, "boot2");
    @(negedge clk);
    checkOutput("boot ram200", 32'(ram[12'h200]), 32'h12);
    checkOutput("boot ram201", 32'(ram[12'h201]), 32'h34);
    checkOutput("boot ram202", 32'(ram[12'h202]), 32'h56);
    checkOutput("boot ld_count", 32'(bus.ld_count), 3);
    checkOutput("boot cpu_halt", 32'(bus.cpu_halt), 1);

    // leaving load mode: halt held through drain, then released
    bus.load_mode = 1'b0;
    @(negedge clk);
    checkOutput("drain cpu_halt", 32'(bus.cpu_halt), 1);
    @(negedge clk);
    checkOutput("run cpu_halt", 32'(bus.cpu_halt), 0);

    // both requesters held: CPU first (priority after reset), then alternate
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 12'h200;
    bus.dbg_req = 1'b1; bus.dbg_addr = 12'h201;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checkOutput($sformatf("rr%0d cpu_gnt", k), 32'(bus.cpu_gnt), 32'(k % 2 == 0));
      checkOutput($sformatf("rr%0d dbg_gnt", k), 32'(bus.dbg_gnt), 32'(k % 2 == 1));
      checkOutput($sformatf("rr%0d cpu_rvalid", k), 32'(bus.cpu_rvalid), 32'(k > 0 && (k % 2 == 1)));
      checkOutput($sformatf("rr%0d dbg_rvalid", k), 32'(bus.dbg_rvalid), 32'(k > 0 && (k % 2 == 0)));
      if (bus.cpu_rvalid) checkOutput($sformatf("rr%0d cpu rdata", k), 32'(bus.rdata), 32'h12);
      if (bus.dbg_rvalid) checkOutput($sformatf("rr%0d dbg rdata", k), 32'(bus.rdata), 32'h34);
    end
    bus.cpu_req = 1'b0;
    bus.dbg_req = 1'b0;
    repeat (2) @(negedge clk);

    // table of single accesses
    for (int i = 0; i < 7; i++) applyStimulus(vecs[i], i);
    @(negedge clk);

    // load_mode rises while a CPU read is in flight
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 12'h300;
    sawGnt = 0;
    for (int c = 0; c < 4 && !sawGnt; c++) begin
      @(negedge clk);
      if (bus.cpu_gnt) sawGnt = 1;
    end
    bus.cpu_req = 1'b0;
    if (!sawGnt) failNote("inflight cpu_gnt");
    bus.load_mode = 1'b1;
    bus.dbg_req = 1'b1; bus.dbg_addr = 12'h300;
    @(negedge clk);
    checkOutput("inflight cpu_rvalid", 32'(bus.cpu_rvalid), 1);
    checkOutput("inflight rdata", 32'(bus.rdata), 32'hAB);
    checkOutput("inflight dbg_gnt", 32'(bus.dbg_gnt), 0);
    checkOutput("inflight cpu_halt", 32'(bus.cpu_halt), 1);
    @(negedge clk);
    checkOutput("inflight dbg_gnt later", 32'(bus.dbg_gnt), 0);
    checkOutput("inflight mem_en", 32'(bus.mem_en), 0);
    bus.dbg_req = 1'b0;
    bus.load_mode = 1'b0;
    repeat (3) @(negedge clk);

    // randomized CPU/debug traffic against a RAM shadow model
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rand start cpu_halt", 32'(bus.cpu_halt), 0);
    for (int i = 0; i < 4096; i++) shadow[i] = ram[i];
    cReq = 0; cDrv = 0; cGntPrev = 0; cRdPend = 0; cWe = 0; cAddr = 0; cWd = 0; cRdExp = 0;
    dReq = 0; dDrv = 0; dGntPrev = 0; dRdPend = 0; dAddr = 0; dRdExp = 0;
    lastWasDbg = 1'b1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      // eligible: request was presented and was not granted in the cycle it was sampled
      winner = 0;
      if ((cDrv && !cGntPrev) && (dDrv && !dGntPrev)) winner = lastWasDbg ? 1 : 2;
      else if (cDrv && !cGntPrev)                     winner = 1;
      else if (dDrv && !dGntPrev)                     winner = 2;
      checkOutput($sformatf("rand%0d cpu_gnt", k), 32'(bus.cpu_gnt), 32'(winner == 1));
      checkOutput($sformatf("rand%0d dbg_gnt", k), 32'(bus.dbg_gnt), 32'(winner == 2));
      checkOutput($sformatf("rand%0d mem_en", k), 32'(bus.mem_en), 32'(winner != 0));
      checkOutput($sformatf("rand%0d cpu_rvalid", k), 32'(bus.cpu_rvalid), 32'(cRdPend));
      checkOutput($sformatf("rand%0d dbg_rvalid", k), 32'(bus.dbg_rvalid), 32'(dRdPend));
      if (cRdPend) checkOutput($sformatf("rand%0d cpu rdata", k), 32'(bus.rdata), 32'(cRdExp));
      if (dRdPend) checkOutput($sformatf("rand%0d dbg rdata", k), 32'(bus.rdata), 32'(dRdExp));
      cRdPend = 0;
      dRdPend = 0;
      if (winner == 1) begin
        checkOutput($sformatf("rand%0d cpu mem_we", k), 32'(bus.mem_we), 32'(cWe));
        checkOutput($sformatf("rand%0d cpu mem_addr", k), 32'(bus.mem_addr), 32'(cAddr));
        if (cWe) begin
          checkOutput($sformatf("rand%0d cpu mem_wdata", k), 32'(bus.mem_wdata), 32'(cWd));
          shadow[cAddr] = cWd;
        end else begin
          cRdPend = 1;
          cRdExp = shadow[cAddr];
        end
        cReq = 0;
        lastWasDbg = 1'b0;
      end else if (winner == 2) begin
        checkOutput($sformatf("rand%0d dbg mem_we", k), 32'(bus.mem_we), 0);
        checkOutput($sformatf("rand%0d dbg mem_addr", k), 32'(bus.mem_addr), 32'(dAddr));
        dRdPend = 1;
        dRdExp = shadow[dAddr];
        dReq = 0;
        lastWasDbg = 1'b1;
      end
      cGntPrev = (winner == 1);
      dGntPrev = (winner == 2);
      if (!cReq && $urandom_range(0, 1) == 1) begin
        cReq = 1'b1;
        cWe = 1'($urandom_range(0, 1));
        cAddr = 12'h300 + 12'($urandom_range(0, 15));
        cWd = 8'($urandom);
      end
      if (!dReq && $urandom_range(0, 1) == 1) begin
        dReq = 1'b1;
        dAddr = 12'h300 + 12'($urandom_range(0, 15));
      end
      bus.cpu_req = cReq; bus.cpu_we = cWe; bus.cpu_addr = cAddr; bus.cpu_wdata = cWd;
      bus.dbg_req = dReq; bus.dbg_addr = dAddr;
      cDrv = cReq;
      dDrv = dReq;
    end
    bus.cpu_req = 1'b0;
    bus.dbg_req = 1'b0;
    repeat (3) @(negedge clk);

    // full load to the top of RAM, then one byte too many
    bus.load_mode = 1'b1;
    @(negedge clk);
    bus.load_start = 1'b1;
    bus.ld_req = 1'b1;
    bus.ld_wdata = 8'h03;
    @(negedge clk);
    checkOutput("start+req ld_gnt", 32'(bus.ld_gnt), 0);
    bus.load_start = 1'b0;
    loadByte(8'h03, 12'h200, "full0");
    for (int i = 1; i < 3584; i++) begin
      lastByte = 8'(i * 7 + 3);
      loadByte(lastByte, 12'h200 + 12'(i), $sformatf("full%0d", i));
    end
    @(negedge clk);
    checkOutput("full ld_count", 32'(bus.ld_count), 3584);
    checkOutput("full ramFFF", 32'(ram[12'hFFF]), 32'(lastByte));
    checkOutput("full ld_err", 32'(bus.ld_err), 0);
    bus.ld_req = 1'b1;
    bus.ld_wdata = 8'h99;
    sawGnt = 0;
    sawEn = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.ld_gnt) sawGnt = 1;
      if (bus.mem_en) sawEn = 1;
    end
    bus.ld_req = 1'b0;
    checkOutput("overflow ld_gnt", 32'(sawGnt), 0);
    checkOutput("overflow mem_en", 32'(sawEn), 0);
    checkOutput("overflow ld_err", 32'(bus.ld_err), 1);
    checkOutput("overflow ramFFF", 32'(ram[12'hFFF]), 32'(lastByte));
    checkOutput("overflow ld_count", 32'(bus.ld_count), 3584);

    // load_start clears the error and restarts at the base address
    bus.load_start = 1'b1;
    @(negedge clk);
    bus.load_start = 1'b0;
    checkOutput("restart ld_err", 32'(bus.ld_err), 0);
    checkOutput("restart ld_count", 32'(bus.ld_count), 0);
    loadByte(8'h77, 12'h200, "restart");
    @(negedge clk);
    checkOutput("restart ram200", 32'(ram[12'h200]), 32'h77);
    checkOutput("restart ld_count1", 32'(bus.ld_count), 1);

    // reset while a CPU read has just been granted
    bus.load_mode = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("prereset cpu_halt", 32'(bus.cpu_halt), 0);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 12'h300;
    sawGnt = 0;
    for (int c = 0; c < 4 && !sawGnt; c++) begin
      @(negedge clk);
      if (bus.cpu_gnt) sawGnt = 1;
    end
    if (!sawGnt) failNote("midreset cpu_gnt");
    bus.cpu_req = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midreset cpu_gnt", 32'(bus.cpu_gnt), 0);
    checkOutput("midreset dbg_gnt", 32'(bus.dbg_gnt), 0);
    checkOutput("midreset ld_gnt", 32'(bus.ld_gnt), 0);
    checkOutput("midreset cpu_rvalid", 32'(bus.cpu_rvalid), 0);
    checkOutput("midreset dbg_rvalid", 32'(bus.dbg_rvalid), 0);
    checkOutput("midreset mem_en", 32'(bus.mem_en), 0);
    checkOutput("midreset ld_count", 32'(bus.ld_count), 0);
    checkOutput("midreset cpu_halt", 32'(bus.cpu_halt), 1);
    reset = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
